snd_cmd_tx: RTL
===============

Name: snd_cmd_tx

Overview:
68K-side sound command transmitter for the TMNT core. It queues command bytes written by the main CPU and presents each byte on the sound data bus. For each byte it generates the SNDDT strobe (the sound board latches the byte on its rising edge) and then the SNDON strobe (the sound board raises the Z80 IRQ on its rising edge). Command pacing is based on a Z80 acknowledge or a timeout, so back-to-back 68K writes are never lost.

Parameters:
DEPTH_LOG2, 2, log2 of command FIFO depth (default 4 entries)
SETUP, 2, cycles SND_DOUT is stable before SNDDT rises (≥1)
DT_WIDTH, 4, SNDDT high time in cycles (≥1)
ON_WIDTH, 4, SNDON high time in cycles (≥1)
ACK_TIMEOUT, 64, max cycles waiting for Z80_ACK; 0 = skip ack wait
MIN_GAP, 16, idle cycles after ack/timeout before next command (≥0)

Ports:
clk_main  in  1  main clock; all logic on its rising edge
RESET  in  1  synchronous, active-high reset
CPU_WR  in  1  one-cycle write strobe from 68K address decode
CPU_DIN  in  8  command byte (M68K data bits 7:0)
Z80_ACK  in  1  one-cycle pulse when Z80 reads the comm reg
SND_DOUT  out  8  byte presented to sound board comm latch
SNDDT  out  1  data latch strobe, active high
SNDON  out  1  sound IRQ request strobe, active high
FIFO_FULL  out  1  count == 2^DEPTH_LOG2
FIFO_EMPTY  out  1  count == 0
OVERFLOW  out  1  sticky: a write was dropped
TIMEOUT  out  1  sticky: an ack wait expired
BUSY  out  1  state != IDLE or FIFO not empty

Behaviour:
- Reset (sync, highest priority): FIFO emptied, state IDLE. SND_DOUT=0x00, SNDDT=0, SNDON=0, FIFO_FULL=0, FIFO_EMPTY=1, OVERFLOW=0, TIMEOUT=0, BUSY=0. Reset mid-transfer drops strobes low on the next edge. Queued bytes are discarded.
- FIFO: circular, registered count of DEPTH_LOG2+1 bits, pointers wrap modulo depth.
  - Write is accepted if not full.
  - Write is also accepted when full if a pop occurs in the same cycle; count is then unchanged.
  - Otherwise the write is dropped and OVERFLOW is set.
  - Pop happens only on the IDLE→SETUP transition.
- All outputs are registered.
- State machine (one transition per clock):
  - IDLE: if FIFO not empty, pop, load SND_DOUT with the head byte, go to SETUP, timer=SETUP-1.
  - SETUP: hold; at timer 0 go to DT, SNDDT←1, timer=DT_WIDTH-1.
  - DT: at timer 0 SNDDT←0, go to HOLD (1 cycle; SND_DOUT still held).
  - HOLD: SNDON←1, go to ON, timer=ON_WIDTH-1, clear ack latch.
  - ON: at timer 0 SNDON←0. Go to WAIT_ACK, or to GAP if ACK_TIMEOUT=0.
  - WAIT_ACK: counter starts at 0. When the ack latch is set, go to GAP. When the counter reaches ACK_TIMEOUT-1 with no ack, set TIMEOUT and go to GAP. Ack wins if both happen in the same cycle.
  - GAP: wait MIN_GAP cycles (0 = immediately to IDLE), then IDLE.
- Ack latch: set by Z80_ACK in states ON and WAIT_ACK. Z80_ACK in any other state is ignored.
- SND_DOUT holds the last byte sent until the next pop. It never changes while SNDDT=1.
- SNDDT and SNDON are never high in the same cycle.
- Latency, empty FIFO, defaults:
  - CPU_WR sampled at edge 0 → pop at edge 1.
  - SNDDT high for edges 3–6, low at edge 7 (HOLD).
  - SNDON high for edges 8–11, low at edge 12.
  - WAIT_ACK entered at edge 12.
- TIMEOUT and OVERFLOW clear only on RESET.

Test Plan:
1. RESET high 3 cycles → all outputs at reset values. Single CPU_WR 0x5A at edge 0, Z80_ACK at edge 14 → SND_DOUT=0x5A from edge 1, SNDDT=1 edges 3–6, SNDON=1 edges 8–11, GAP 16 cycles, BUSY=0 afterwards, TIMEOUT=0.
2. Write 0x01..0x04 on 4 consecutive cycles, ack each → bytes sent in order 0x01,0x02,0x03,0x04. FIFO_FULL never set (max count 3 because of the first pop). OVERFLOW=0.
3. Write 6 bytes consecutively (0x10..0x15) with no ack → FIFO fills. One write is dropped, OVERFLOW=1. 5 bytes transmitted in order. Each ack wait lasts 64 cycles, TIMEOUT=1.
4. Z80_ACK asserted during SNDON high → latched; WAIT_ACK exits after 1 cycle. Z80_ACK during SETUP → ignored; TIMEOUT is set after 64 cycles.
5. Write while full, same cycle as an IDLE pop → write accepted, count unchanged, OVERFLOW stays 0.
6. RESET asserted while SNDDT=1 with 2 bytes queued → SNDDT=0 next edge, FIFO_EMPTY=1. No further strobes until a new write.

Source files
------------

// File: rtl/snd_cmd_tx.sv
`default_nettype none
// ============================================================================
//  Module      : snd_cmd_tx
//  Description : 68K-side sound command transmitter. Queues command bytes
//                from the main CPU and, per byte, drives SND_DOUT, then an
//                SNDDT latch strobe, then an SNDON IRQ strobe, then waits for
//                a Z80 acknowledge (or timeout) and a minimum idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module snd_cmd_tx #(
    parameter int DEPTH_LOG2  = 2,
    parameter int SETUP       = 2,
    parameter int DT_WIDTH    = 4,
    parameter int ON_WIDTH    = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter int MIN_GAP     = 16
) (
    input  logic       clk_main,
    input  logic       RESET,
    input  logic       CPU_WR,
    input  logic [7:0] CPU_DIN,
    input  logic       Z80_ACK,
    output logic [7:0] SND_DOUT,
    output logic       SNDDT,
    output logic       SNDON,
    output logic       FIFO_FULL,
    output logic       FIFO_EMPTY,
    output logic       OVERFLOW,
    output logic       TIMEOUT,
    output logic       BUSY
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    // One shared 16-bit timer covers every phase length and the ack counter.
    localparam int c_TW    = 16;

    localparam logic [DEPTH_LOG2:0]   c_COUNT_FULL = (DEPTH_LOG2+1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0]   c_COUNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [c_TW-1:0]       c_T_ONE      = c_TW'(1);
    localparam logic [c_TW-1:0]       c_SETUP_LD   = c_TW'(SETUP - 1);
    localparam logic [c_TW-1:0]       c_DT_LD      = c_TW'(DT_WIDTH - 1);
    localparam logic [c_TW-1:0]       c_ON_LD      = c_TW'(ON_WIDTH - 1);
    localparam logic [c_TW-1:0]       c_ACK_LAST   = c_TW'(ACK_TIMEOUT - 1);
    localparam logic [c_TW-1:0]       c_GAP_LD     = (MIN_GAP == 0) ? '0 : c_TW'(MIN_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_DT       = 3'd2,
        S_HOLD     = 3'd3,
        S_ON       = 3'd4,
        S_WAIT_ACK = 3'd5,
        S_GAP      = 3'd6
    } state_t;

    // A zero gap skips the GAP state and returns straight to IDLE.
    localparam state_t c_AFTER_ACK = (MIN_GAP == 0) ? S_IDLE : S_GAP;

    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
    logic [DEPTH_LOG2:0]   r_count, w_count_nxt;
    state_t                r_state, w_state_nxt;
    logic [c_TW-1:0]       r_timer, w_timer_nxt;
    logic                  r_ack, w_ack_nxt;
    logic [7:0]            r_dout, w_dout_nxt;
    logic                  r_dt, w_dt_nxt;
    logic                  r_on, w_on_nxt;
    logic                  r_ovf, w_ovf_nxt;
    logic                  r_tmo, w_tmo_nxt;
    logic                  r_busy, r_full, r_empty;
    logic                  w_pop, w_wr_ok;

    // FIFO accounting: a pop frees a slot in the same cycle, so a write to a
    // full FIFO is still taken when the state machine pops alongside it.
    always_comb begin
        w_pop   = (r_state == S_IDLE) && (r_count != '0);
        w_wr_ok = CPU_WR && ((r_count != c_COUNT_FULL) || w_pop);
        w_ovf_nxt = r_ovf || (CPU_WR && !w_wr_ok);
        case ({w_wr_ok, w_pop})
            2'b10:   w_count_nxt = r_count + c_COUNT_ONE;
            2'b01:   w_count_nxt = r_count - c_COUNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Transfer sequencer: next state, timer, ack latch and strobe values.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_ack_nxt   = r_ack;
        w_dout_nxt  = r_dout;
        w_dt_nxt    = r_dt;
        w_on_nxt    = r_on;
        w_tmo_nxt   = r_tmo;
        if ((r_state == S_ON || r_state == S_WAIT_ACK) && Z80_ACK)
            w_ack_nxt = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_dout_nxt  = r_mem[r_rptr];
                    w_state_nxt = S_SETUP;
                    w_timer_nxt = c_SETUP_LD;
                end
            end
            S_SETUP: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_DT;
                    w_dt_nxt    = 1'b1;
                    w_timer_nxt = c_DT_LD;
                end else begin
                    w_timer_nxt = r_timer - c_T_ONE;
                end
            end
            S_DT: begin
                if (r_timer == '0) begin
                    w_dt_nxt    = 1'b0;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_timer_nxt = r_timer - c_T_ONE;
                end
            end
            S_HOLD: begin
                w_on_nxt    = 1'b1;
                w_state_nxt = S_ON;
                w_timer_nxt = c_ON_LD;
                w_ack_nxt   = 1'b0;
            end
            S_ON: begin
                if (r_timer == '0) begin
                    w_on_nxt = 1'b0;
                    if (ACK_TIMEOUT == 0) begin
                        w_state_nxt = c_AFTER_ACK;
                        w_timer_nxt = c_GAP_LD;
                    end else begin
                        w_state_nxt = S_WAIT_ACK;
                        w_timer_nxt = '0;
                    end
                end else begin
                    w_timer_nxt = r_timer - c_T_ONE;
                end
            end
            S_WAIT_ACK: begin
                // Ack is tested first so it wins over a coincident timeout.
                if (r_ack) begin
                    w_state_nxt = c_AFTER_ACK;
                    w_timer_nxt = c_GAP_LD;
                end else if (r_timer == c_ACK_LAST) begin
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = c_AFTER_ACK;
                    w_timer_nxt = c_GAP_LD;
                end else begin
                    w_timer_nxt = r_timer + c_T_ONE;
                end
            end
            S_GAP: begin
                if (r_timer == '0)
                    w_state_nxt = S_IDLE;
                else
                    w_timer_nxt = r_timer - c_T_ONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_main) begin
        if (w_wr_ok)
            r_mem[r_wptr] <= CPU_DIN;
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk_main) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_ack   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_dout  <= 8'h00;
            r_dt    <= 1'b0;
            r_on    <= 1'b0;
            r_ovf   <= 1'b0;
            r_tmo   <= 1'b0;
            r_busy  <= 1'b0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_ack   <= w_ack_nxt;
            if (w_wr_ok) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_pop)   r_rptr <= r_rptr + c_PTR_ONE;
            r_count <= w_count_nxt;
            r_dout  <= w_dout_nxt;
            r_dt    <= w_dt_nxt;
            r_on    <= w_on_nxt;
            r_ovf   <= w_ovf_nxt;
            r_tmo   <= w_tmo_nxt;
            r_busy  <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
            r_full  <= (w_count_nxt == c_COUNT_FULL);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign SND_DOUT   = r_dout;
    assign SNDDT      = r_dt;
    assign SNDON      = r_on;
    assign FIFO_FULL  = r_full;
    assign FIFO_EMPTY = r_empty;
    assign OVERFLOW   = r_ovf;
    assign TIMEOUT    = r_tmo;
    assign BUSY       = r_busy;

endmodule
`default_nettype wire
